// File: rtl/guess_search_ctrl_pkg.sv
// Shared definitions for the binary-search guess controller:
// default operand width and the binary state encoding.
package guess_search_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/guess_search_ctrl_if.sv
// Guess/result handshake between the search controller (master) and the
// magnitude comparator that judges each guess (slave).
interface guess_search_ctrl_if
    import guess_search_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] guess;
    logic             guess_valid;
    logic             cmp_valid;
    logic             G;
    logic             E;
    logic             L;

    modport master (
        output guess,
        output guess_valid,
        input  cmp_valid,
        input  G,
        input  E,
        input  L
    );

    modport slave (
        input  guess,
        input  guess_valid,
        output cmp_valid,
        output G,
        output E,
        output L
    );

endinterface

// File: rtl/guess_search_ctrl.sv
// Binary-search controller: narrows [lo, hi] from comparator G/E/L feedback
// until the hidden value is matched or the feedback proves inconsistent.
module guess_search_ctrl
    import guess_search_ctrl_pkg::*;
#(
    parameter  int WIDTH   = DEFAULT_WIDTH,
    localparam int STEPS_W = $clog2(WIDTH + 2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    guess_search_ctrl_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [WIDTH-1:0]     result,
    output logic [STEPS_W-1:0]   steps
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    state_t           state;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] guess;
    logic [WIDTH-1:0] mid;
    logic [WIDTH:0]   guess_inc;
    logic [WIDTH:0]   guess_dec;

    // Midpoint and neighbours are formed one bit wider so nothing wraps.
    assign mid       = WIDTH'({1'b0, lo} + (({1'b0, hi} - {1'b0, lo}) >> 1));
    assign guess_inc = {1'b0, guess} + (WIDTH+1)'(1);
    assign guess_dec = {1'b0, guess} - (WIDTH+1)'(1);

    assign busy            = (state != ST_IDLE);
    assign done            = (state == ST_DONE);
    assign bus.guess_valid = (state == ST_WAIT);
    assign bus.guess       = guess;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            lo     <= '0;
            hi     <= '0;
            guess  <= '0;
            found  <= 1'b0;
            result <= '0;
            steps  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lo    <= '0;
                        hi    <= MAX_VAL;
                        steps <= '0;
                        found <= 1'b0;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    guess <= mid;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.cmp_valid) begin
                        steps <= steps + STEPS_W'(1);
                        state <= ST_DONE;
                        // Only a one-hot result that keeps lo <= hi continues the search.
                        case ({bus.G, bus.E, bus.L})
                            3'b010: begin
                                result <= guess;
                                found  <= 1'b1;
                            end
                            3'b100: begin
                                if (guess != MAX_VAL) begin
                                    lo <= guess_inc[WIDTH-1:0];
                                    if (guess_inc <= {1'b0, hi})
                                        state <= ST_ISSUE;
                                end
                            end
                            3'b001: begin
                                if (guess != '0) begin
                                    hi <= guess_dec[WIDTH-1:0];
                                    if (guess_dec >= {1'b0, lo})
                                        state <= ST_ISSUE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_guess_search_ctrl.sv
// Self-checking bench for guess_search_ctrl: a behavioural comparator
// responder plus an arithmetic binary-search reference model.
module tb_guess_search_ctrl;
    import guess_search_ctrl_pkg::*;

    localparam int WIDTH   = 8;
    localparam int STEPS_W = $clog2(WIDTH + 2);
    localparam int MAXV    = (1 << WIDTH) - 1;

    typedef enum int {M_NORMAL, M_ALL_G, M_ALL_L, M_BOTH, M_NONE} mode_e;

    typedef struct {
        int    hidden;
        mode_e mode;
        int    exp_found;
        int    exp_steps;
        int    exp_result;
        int    exp_last_guess;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               busy;
    logic               done;
    logic               found;
    logic [WIDTH-1:0]   result;
    logic [STEPS_W-1:0] steps;

    int    hidden;
    mode_e mode;
    logic  stall;

    int tests  = 0;
    int failed = 0;
    int obs_q[$];
    int exp_q[$];

    guess_search_ctrl_if #(.WIDTH(WIDTH)) bus ();

    guess_search_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bus    (bus),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .result (result),
        .steps  (steps)
    );

    always #5 clk = ~clk;

    // Zero-latency comparator; stall withholds cmp_valid, mode injects faulty answers.
    always_comb begin
        bus.cmp_valid = bus.guess_valid && !stall;
        bus.G = 1'b0;
        bus.E = 1'b0;
        bus.L = 1'b0;
        case (mode)
            M_NORMAL: begin
                bus.G = hidden > int'(bus.guess);
                bus.E = hidden == int'(bus.guess);
                bus.L = hidden < int'(bus.guess);
            end
            M_ALL_G: bus.G = 1'b1;
            M_ALL_L: bus.L = 1'b1;
            M_BOTH: begin
                bus.G = 1'b1;
                bus.L = 1'b1;
            end
            default: ;
        endcase
    end

    always @(posedge clk) begin
        if (bus.guess_valid && bus.cmp_valid)
            obs_q.push_back(int'(bus.guess));
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Plain interval bisection over integers, driven by what the responder would answer.
    task automatic model_search(input int h, input mode_e m, output int f, output int n, output int r);
        int lo = 0;
        int hi = MAXV;
        int g;
        bit gt, eq, lt;
        f = 0;
        n = 0;
        r = 0;
        exp_q.delete();
        for (int it = 0; it < 32; it++) begin
            g = (lo + hi) / 2;
            exp_q.push_back(g);
            n++;
            gt = 0; eq = 0; lt = 0;
            case (m)
                M_NORMAL: begin gt = h > g; eq = h == g; lt = h < g; end
                M_ALL_G:  gt = 1;
                M_ALL_L:  lt = 1;
                M_BOTH:   begin gt = 1; lt = 1; end
                default:  ;
            endcase
            if (int'(gt) + int'(eq) + int'(lt) != 1) return;
            if (eq) begin
                f = 1;
                r = g;
                return;
            end
            if (gt) begin
                if (g == MAXV) return;
                lo = g + 1;
            end else begin
                if (g == 0) return;
                hi = g - 1;
            end
            if (lo > hi) return;
        end
    endtask

    task automatic compare_seq(input string tag);
        check_output({tag, "_guess_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check_output($sformatf("%s_guess%0d", tag, i), obs_q[i], exp_q[i]);
    endtask

    // Launches one search and waits (bounded) for the done pulse.
    task automatic apply_stimulus(input int h, input mode_e m, input bit rand_stall,
                                  output int cycles);
        hidden = h;
        mode   = m;
        obs_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        while (!done && cycles < 600) begin
            if (rand_stall) stall = 1'($urandom_range(0, 1));
            @(negedge clk);
            cycles++;
        end
        stall = 1'b0;
        check_output("done_seen", int'(done), 1);
    endtask

    initial begin
        vec_t vecs[8];
        int   seq100[8];
        int   cycles, f, n, r, waited;
        bit   saw_done;

        vecs[0] = '{100, M_NORMAL, 1, 8, 100, 100};
        vecs[1] = '{255, M_NORMAL, 1, 9, 255, 255};
        vecs[2] = '{0,   M_NORMAL, 1, 8, 0,   0};
        vecs[3] = '{127, M_NORMAL, 1, 1, 127, 127};
        vecs[4] = '{0,   M_ALL_G,  0, 9, 0,   255};
        vecs[5] = '{0,   M_ALL_L,  0, 8, 0,   0};
        vecs[6] = '{0,   M_BOTH,   0, 1, 0,   127};
        vecs[7] = '{0,   M_NONE,   0, 1, 0,   127};
        seq100  = '{127, 63, 95, 111, 103, 99, 101, 100};

        rst_n  = 1'b0;
        start  = 1'b0;
        stall  = 1'b0;
        mode   = M_NORMAL;
        hidden = 0;
        repeat (2) @(negedge clk);
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_done", int'(done), 0);
        check_output("reset_found", int'(found), 0);
        check_output("reset_steps", int'(steps), 0);
        check_output("reset_guess", int'(bus.guess), 0);
        check_output("reset_guess_valid", int'(bus.guess_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("idle_after_reset", int'(busy), 0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].hidden, vecs[i].mode, 1'b0, cycles);
            check_output($sformatf("vec%0d_found", i), int'(found), vecs[i].exp_found);
            check_output($sformatf("vec%0d_steps", i), int'(steps), vecs[i].exp_steps);
            if (vecs[i].exp_found == 1)
                check_output($sformatf("vec%0d_result", i), int'(result), vecs[i].exp_result);
            check_output($sformatf("vec%0d_last_guess", i),
                         (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : -1, vecs[i].exp_last_guess);
            check_output($sformatf("vec%0d_cycles", i), cycles, 2 * vecs[i].exp_steps + 1);
            model_search(vecs[i].hidden, vecs[i].mode, f, n, r);
            compare_seq($sformatf("vec%0d", i));
            if (i == 0)
                foreach (seq100[k])
                    check_output($sformatf("hidden100_guess%0d", k),
                                 (k < obs_q.size()) ? obs_q[k] : -1, seq100[k]);
        end

        // Comparator stalls on the first guess: guess must hold with guess_valid high.
        hidden = 100;
        mode   = M_NORMAL;
        stall  = 1'b1;
        obs_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while (!bus.guess_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        for (int c = 0; c < 5; c++) begin
            check_output($sformatf("stall%0d_guess", c), int'(bus.guess), 127);
            check_output($sformatf("stall%0d_guess_valid", c), int'(bus.guess_valid), 1);
            @(negedge clk);
        end
        stall  = 1'b0;
        waited = 0;
        while (!done && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_output("stall_done_seen", int'(done), 1);
        check_output("stall_found", int'(found), 1);
        check_output("stall_steps", int'(steps), 8);
        model_search(100, M_NORMAL, f, n, r);
        compare_seq("stall");

        // A start pulse mid-search and one on the done cycle must both be ignored.
        obs_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while (!done && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_output("busy_start_done_seen", int'(done), 1);
        check_output("busy_start_steps", int'(steps), 8);
        check_output("busy_start_result", int'(result), 100);
        compare_seq("busy_start");
        start = 1'b1;
        @(negedge clk);
        check_output("done_cycle_start_busy", int'(busy), 0);
        start = 1'b0;
        @(negedge clk);
        check_output("done_cycle_start_still_idle", int'(busy), 0);

        // Reset during the WAIT of the third guess abandons the search.
        obs_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while (!(obs_q.size() == 2 && bus.guess_valid) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_output("rst_reached_third_wait", int'(bus.guess_valid), 1);
        rst_n = 1'b0;
        #1;
        check_output("rst_guess", int'(bus.guess), 0);
        check_output("rst_guess_valid", int'(bus.guess_valid), 0);
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_done", int'(done), 0);
        check_output("rst_found", int'(found), 0);
        check_output("rst_result", int'(result), 0);
        check_output("rst_steps", int'(steps), 0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (done) saw_done = 1'b1;
        check_output("rst_no_done_pulse", int'(saw_done), 0);
        apply_stimulus(100, M_NORMAL, 1'b0, cycles);
        check_output("post_rst_first_guess", (obs_q.size() > 0) ? obs_q[0] : -1, 127);
        check_output("post_rst_found", int'(found), 1);
        check_output("post_rst_steps", int'(steps), 8);
        model_search(100, M_NORMAL, f, n, r);
        compare_seq("post_rst");

        // Random hidden values and responder modes with random comparator stalls.
        for (int t = 0; t < 40; t++) begin
            int    h;
            mode_e m;
            bit    rs;
            h  = $urandom_range(0, MAXV);
            m  = ($urandom_range(0, 3) == 0) ? mode_e'($urandom_range(1, 4)) : M_NORMAL;
            rs = 1'($urandom_range(0, 1));
            model_search(h, m, f, n, r);
            apply_stimulus(h, m, rs, cycles);
            check_output($sformatf("rand%0d_found", t), int'(found), f);
            check_output($sformatf("rand%0d_steps", t), int'(steps), n);
            if (f == 1)
                check_output($sformatf("rand%0d_result", t), int'(result), r);
            compare_seq($sformatf("rand%0d", t));
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/guess_search_ctrl.md
GUESS_SEARCH_CTRL -- requirements
Module: guess_search_ctrl

Interface
REQ-001 Parameter WIDTH, default 8; width of the searched value and of the guess.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a search; sampled only in IDLE.
REQ-005 guess  output  WIDTH  candidate value driven to the comparator's b operand.
REQ-006 guess_valid  output  1  high while guess is presented and awaiting a result.
REQ-007 cmp_valid  input  1  comparator result valid; sampled only in WAIT.
REQ-008 G, E, L  input  1 each  comparator result: hidden value greater than, equal to, or less than guess.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when a search ends.
REQ-011 found  output  1  on done, 1 = match, 0 = error; held until next start.
REQ-012 result  output  WIDTH  matched value; valid when done=1 and found=1; held until next start.
REQ-013 steps  output  clog2(WIDTH+2)  number of comparisons consumed; held until next start.

Function
REQ-014 States: IDLE, ISSUE, WAIT, DONE; binary-encoded.
REQ-015 IDLE + start=1 -> lo=0, hi=2^WIDTH-1, steps=0, found=0; next state ISSUE.
REQ-016 IDLE + start=0 -> remain IDLE; start in any other state is ignored.
REQ-017 ISSUE: guess registered as lo + ((hi-lo)>>1), computed at WIDTH+1 bits so no overflow; next state WAIT.
REQ-018 guess_valid=1 in WAIT only; guess stays stable throughout WAIT.
REQ-019 WAIT + cmp_valid=0 -> remain WAIT indefinitely; no timeout.
REQ-020 WAIT + cmp_valid=1: steps increments by 1, then exactly one of REQ-021..REQ-025 applies.
REQ-021 E=1 only: result=guess, found=1 -> DONE.
REQ-022 G=1 only with guess < 2^WIDTH-1: lo=guess+1 -> ISSUE.
REQ-023 L=1 only with guess > 0: hi=guess-1 -> ISSUE.
REQ-024 Wrap-around guard: G with guess=2^WIDTH-1, or L with guess=0, -> found=0 -> DONE; lo/hi never wrap.
REQ-025 G/E/L not one-hot (none set or more than one set) -> found=0 -> DONE.
REQ-026 Inconsistent results driving lo>hi after an update -> found=0 -> DONE, with no further ISSUE.
REQ-027 DONE: done=1 for one cycle -> IDLE; a start on that cycle is ignored.
REQ-028 With consistent comparator results the search ends with found=1 within WIDTH+1 comparisons.
REQ-029 With cmp_valid returned on the first WAIT cycle, each comparison costs 2 cycles: ISSUE then WAIT.

Reset
REQ-030 rst_n=0 asynchronously forces IDLE and clears guess, guess_valid, busy, done, found, result, steps, lo and hi to 0.
REQ-031 Reset asserted mid-search abandons the search; no done pulse is produced.
REQ-032 After rst_n deasserts, the first rising edge behaves as IDLE.

Structure
REQ-033 A shared package holds the state typedef/encoding and the default WIDTH constant.
REQ-034 No sub-module is required; midpoint arithmetic stays inline.
REQ-035 Top-level pairing: guess drives the magnitude comparator's b input, and its G/E/L feed back here.

Verification
REQ-036 WIDTH=8, hidden 100, zero-latency comparator -> guesses 127,63,95,111,103,99,101,100; done with found=1, result=100, steps=8.
REQ-037 Hidden 255 -> final guess 255 after 9 comparisons, found=1, and lo never wraps. Hidden 0 -> guesses end 3,1,0, steps=8, found=1.
REQ-038 Responder drives G=1 for every guess -> at guess=255 the wrap guard triggers: done, found=0, steps=9.
REQ-039 cmp_valid held low for 5 cycles on the first guess -> guess stays 127 with guess_valid high throughout; the search then resumes normally.
REQ-040 G and L both set on the first result -> done, found=0, steps=1. start pulsed while busy -> ignored.
REQ-041 rst_n pulsed low during WAIT of the 3rd guess -> all outputs go to 0 immediately with no done pulse; a new start then searches from lo=0, hi=255.
